// File: rtl/cam_pkg.sv
// cam_pkg: FSM states and default OV7670 geometry shared by the camera stream blocks.
package cam_pkg;
    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;
    localparam int LINE_BYTES_D  = 160;
    localparam int H_BLANK_D     = 16;
    localparam int LINES_D       = 120;
    localparam int VSYNC_LINES_D = 3;
    localparam int V_BACK_D      = 2;
    localparam int V_FRONT_D     = 2;
    localparam int ADDR_W        = 15;
endpackage

// File: rtl/cam_stream_gen_if.sv
// cam_stream_gen_if: OV7670-style parallel camera bus (vsync, href, d).
interface cam_stream_gen_if;
    logic       vsync;
    logic       href;
    logic [7:0] d;
    modport master (output vsync, href, d);
    modport slave (input vsync, href, d);
endinterface

// File: rtl/cam_stream_gen.sv
// cam_stream_gen: replays a stored frame from a sync RAM as an OV7670-style vsync/href/d stream.
module cam_stream_gen
    import cam_pkg::*;
#(
    parameter int LINE_BYTES  = LINE_BYTES_D,
    parameter int H_BLANK     = H_BLANK_D,
    parameter int LINES       = LINES_D,
    parameter int VSYNC_LINES = VSYNC_LINES_D,
    parameter int V_BACK      = V_BACK_D,
    parameter int V_FRONT     = V_FRONT_D
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [7:0]        rd_data,
    cam_stream_gen_if.master  cam,
    output logic              frame_done
);
    localparam int L  = LINE_BYTES + H_BLANK;
    localparam int HW = $clog2(L);
    localparam int VW = 16;

    if (LINES * LINE_BYTES > 32768 || LINE_BYTES < 1 || H_BLANK < 1 || LINES < 1 ||
        VSYNC_LINES < 1 || V_BACK < 1 || V_FRONT < 1) begin : g_bad_geometry
        $error("cam_stream_gen: invalid frame geometry");
    end

    state_t state, state_n;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [ADDR_W-1:0] addr;
    logic vs_q, hr_q, fd_q;
    logic last_h, line_end, fd_s0;
    int lines_n;

    assign lines_n  = state == VSYNC ? VSYNC_LINES : state == VBACK ? V_BACK :
                      state == ACTIVE ? LINES : V_FRONT;
    assign last_h   = h_cnt == HW'(L - 1);
    assign line_end = last_h && v_cnt == VW'(lines_n - 1);
    assign rd_en    = state == ACTIVE && h_cnt < HW'(LINE_BYTES);
    assign rd_addr  = rd_en ? addr : '0;
    assign fd_s0    = state == VFRONT && line_end;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = en ? VSYNC : IDLE;
            VSYNC:   state_n = line_end ? VBACK : VSYNC;
            VBACK:   state_n = line_end ? ACTIVE : VBACK;
            ACTIVE:  state_n = line_end ? VFRONT : ACTIVE;
            VFRONT:  state_n = line_end ? (en ? VSYNC : IDLE) : VFRONT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    // addr is parked at 0 throughout VSYNC so every frame restarts from the first byte
    always_ff @(posedge pclk) begin
        if (!rst_n || state == IDLE) begin
            h_cnt <= '0;
            v_cnt <= '0;
            addr  <= '0;
        end else begin
            h_cnt <= last_h ? '0 : h_cnt + 1'b1;
            v_cnt <= line_end ? '0 : last_h ? v_cnt + 1'b1 : v_cnt;
            addr  <= state == VSYNC ? '0 : addr + ADDR_W'(rd_en);
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            vs_q <= 1'b0;
            hr_q <= 1'b0;
            fd_q <= 1'b0;
        end else begin
            vs_q <= state == VSYNC;
            hr_q <= rd_en;
            fd_q <= fd_s0;
        end
    end

    assign cam.vsync  = vs_q;
    assign cam.href   = hr_q;
    assign cam.d      = hr_q ? rd_data : 8'h00;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_cam_stream_gen.sv
// tb_cam_stream_gen: random frame contents replayed and checked cycle by cycle against a frame-position model.
module tb_cam_stream_gen;
    import cam_pkg::*;
    localparam int L      = LINE_BYTES_D + H_BLANK_D;
    localparam int FIRST  = VSYNC_LINES_D + V_BACK_D;
    localparam int FRAME  = (VSYNC_LINES_D + V_BACK_D + LINES_D + V_FRONT_D) * L;
    localparam int NBYTES = LINES_D * LINE_BYTES_D;

    logic pclk = 1'b0, rst_n = 1'b0, en = 1'b0;
    logic [ADDR_W-1:0] rd_addr;
    logic rd_en, frame_done;
    logic [7:0] rd_data;
    logic [7:0] mem [NBYTES];

    cam_stream_gen_if cam ();

    cam_stream_gen dut (
        .pclk(pclk), .rst_n(rst_n), .en(en), .rd_addr(rd_addr), .rd_en(rd_en),
        .rd_data(rd_data), .cam(cam.master), .frame_done(frame_done)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) if (rd_en) rd_data <= mem[rd_addr];

    int tests = 0, fails = 0;
    int p = -1, op = -1;
    int cyc = 0, fd_cnt = 0, href_cnt = 0, vs_len = 0, last_vs_len = 0;
    int rises[$];
    logic vs_prev = 1'b0;

    task automatic chk(input string tag, input int o, input int e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, o, e);
        end
    endtask

    // p: frame position of the read stage (-1 idle); op: position shown on the outputs
    task automatic tick();
        int ol, oc, sl, sc;
        logic ev, eh, ef, er;
        @(posedge pclk);
        op = rst_n ? p : -1;
        p = !rst_n ? -1 : (p < 0 || p == FRAME - 1) ? (en ? 0 : -1) : p + 1;
        #1;
        cyc++;
        ol = op / L; oc = op % L; sl = p / L; sc = p % L;
        ev = op >= 0 && ol < VSYNC_LINES_D;
        eh = op >= 0 && ol >= FIRST && ol < FIRST + LINES_D && oc < LINE_BYTES_D;
        ef = op == FRAME - 1;
        er = p >= 0 && sl >= FIRST && sl < FIRST + LINES_D && sc < LINE_BYTES_D;
        chk("vsync", int'(cam.vsync), int'(ev));
        chk("href", int'(cam.href), int'(eh));
        chk("d", int'(cam.d), eh ? int'(mem[(ol - FIRST) * LINE_BYTES_D + oc]) : 0);
        chk("frame_done", int'(frame_done), int'(ef));
        chk("rd_en", int'(rd_en), int'(er));
        chk("rd_addr", int'(rd_addr), er ? (sl - FIRST) * LINE_BYTES_D + sc : 0);
        if (frame_done) fd_cnt++;
        if (cam.href) href_cnt++;
        if (cam.vsync && !vs_prev) rises.push_back(cyc);
        if (cam.vsync) vs_len++;
        else if (vs_prev) begin
            last_vs_len = vs_len;
            vs_len = 0;
        end
        vs_prev = cam.vsync;
    endtask

    initial begin
        for (int i = 0; i < NBYTES; i++) mem[i] = 8'($urandom);
        rst_n = 1'b0;
        en = 1'b1;
        repeat (5) tick();
        rst_n = 1'b1;
        en = 1'b0;
        repeat ($urandom_range(20, 1)) tick();
        en = 1'b1;
        repeat (FRAME + (FIRST + 50) * L + int'($urandom_range(LINE_BYTES_D - 1, 0))) tick();
        en = 1'b0;
        repeat (FRAME - (FIRST + 50) * L + 300) tick();
        chk("frame_done_count", fd_cnt, 2);
        chk("href_cycles", href_cnt, 2 * NBYTES);
        chk("vsync_rises", rises.size(), 2);
        if (rises.size() == 2) chk("frame_period", rises[1] - rises[0], FRAME);
        chk("vsync_len", last_vs_len, VSYNC_LINES_D * L);
        en = 1'b1;
        for (int i = 0; i < 2 * FRAME && p != (FIRST + 10) * L + 80; i++) tick();
        chk("reached_midline", p, (FIRST + 10) * L + 80);
        rst_n = 1'b0;
        tick();
        chk("reset_vsync", int'(cam.vsync), 0);
        chk("reset_href", int'(cam.href), 0);
        rst_n = 1'b1;
        vs_len = 0;
        repeat ((FIRST + 1) * L + 10) tick();
        chk("restart_vsync_len", last_vs_len, VSYNC_LINES_D * L);
        chk("restart_rises", rises.size(), 4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
